mult_acc_sched: RTL and testbench
=================================

Name: mult_acc_sched

Overview:
- Frame scheduler for the two-stream multiply-accumulate datapath.
- Pops the two operand FIFOs strictly in lockstep and counts element and packet positions across a frame (AMOUNT_OF_PACKET packets of AMOUNT_OF_DATA pairs).
- Drives pipeline-aligned accumulator controls (write enable, address, first/last-packet flags).
- Reports frame completion to the host via a start/busy/done handshake.

Parameters:
- AMOUNT_OF_DATA, 16, pairs per packet; equals accumulator depth; must be >= 2.
- AMOUNT_OF_PACKET, 4, packets accumulated per frame; must be >= 1.
- PIPE_DEPTH, 2, cycles from FIFO pop to product at the accumulator; must be >= 1.
- STALL_CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  frame start request; single-cycle pulse
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse on frame completion
- f1_empty  in  1  operand FIFO 1 empty (first-word-fall-through)
- f2_empty  in  1  operand FIFO 2 empty
- f1_rd  out  1  FIFO 1 pop; consumes the head word this cycle
- f2_rd  out  1  FIFO 2 pop
- acc_we  out  1  product valid at the accumulator this cycle
- acc_addr  out  ADDR_W  accumulator slot; ADDR_W = max(1, $clog2(AMOUNT_OF_DATA))
- acc_first  out  1  write product (packet 0) instead of adding to the slot
- res_valid  out  1  final packet; accumulator presents slot result as output

Behaviour:
- Reset: async assert when rst=0.
  - All outputs 0, FSM in IDLE, counters 0, all sideband valids cleared.
  - Reset mid-frame abandons the frame; no done is issued.
- FSM states:
  - IDLE: busy=0. start=1 -> RUN with elem_cnt=0, pkt_cnt=0.
  - RUN: busy=1.
    - pop = !f1_empty & !f2_empty; f1_rd = f2_rd = pop (combinational, same cycle).
    - Never pop one FIFO alone.
    - On pop: elem_cnt increments and wraps AMOUNT_OF_DATA-1 -> 0; pkt_cnt increments on wrap.
    - Pop at elem=N-1, pkt=P-1 -> DRAIN with drain_cnt=PIPE_DEPTH-1.
  - DRAIN: busy=1, no pops.
    - drain_cnt decrements each cycle.
    - drain_cnt==0: done=1 this cycle, next state IDLE.
- Sideband pipeline, PIPE_DEPTH registers deep:
  - Entry written every cycle: {valid=pop, addr=elem_cnt, first=(pkt_cnt==0), last=(pkt_cnt==P-1)}.
  - Tail drives acc_we=valid, acc_addr, acc_first=first&valid, res_valid=last&valid.
  - acc_addr holds its last value when valid=0.
- Latency:
  - A pop at cycle T gives acc_we at T+PIPE_DEPTH.
  - done coincides with the final acc_we/res_valid of the frame.
  - Back-to-back pops give back-to-back acc_we with no bubbles.
- start is ignored while busy=1, including the done cycle. A new frame may start the cycle after done.
- P=1: every write has acc_first=1 and res_valid=1.
- The empty flags are sampled in every RUN cycle. Stalls of any length are legal and only delay the schedule.

Optional Feature:
- Macro: MULT_ACC_SCHED_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [STALL_CNT_W-1:0].
  - Counts RUN cycles with pop=0 and saturates at all-ones.
  - Cleared on reset and on each accepted start; holds its value after done.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package mult_acc_sched_pkg holds:
  - State enum (IDLE, RUN, DRAIN).
  - Sideband struct {valid, addr, first, last}, parameterised via ADDR_W.
  - Function computing ADDR_W.
- One sub-module: mult_acc_sched_sb_pipe, a PIPE_DEPTH-stage delay line of the sideband struct with async active-low clear of valid bits.

Test Plan (defaults N=16, P=4, PIPE_DEPTH=2):
- Both FIFOs never empty, start pulse at cycle C -> f1_rd=f2_rd high C+1..C+64.
  - acc_we high C+3..C+66.
  - acc_first on the first 16 writes, addrs 0..15.
  - res_valid on the last 16 writes, addrs 0..15.
  - done exactly at C+66; busy falls at C+67.
- f2_empty random at 50%, f1_empty random at 30% -> f1_rd==f2_rd in every cycle, never asserted while either empty.
  - Exactly 64 pops, 64 acc_we, addr sequence 0..15 repeated 4 times, one done.
- start re-pulsed at pop 10 and again in the done cycle -> both ignored; exactly one done and 64 pops.
- rst=0 asynchronously mid-RUN after pop 20 -> all outputs 0 immediately, no done, in-flight acc_we suppressed.
  - Following start produces a full 64-pop frame beginning with acc_first at addr 0.
- Two frames, second start issued the cycle after done -> second frame restarts with acc_first at addr 0; two done pulses, 128 acc_we total.
- With MULT_ACC_SCHED_STALL_CNT_EN, f1_empty held high for 7 RUN cycles mid-frame -> stall_cnt=7 after done.
  - stall_cnt clears to 0 on the next accepted start.

Source files
------------

// File: rtl/mult_acc_sched_pkg.sv
// mult_acc_sched_pkg: state encoding, sideband record and width helper shared by the MAC frame scheduler.
package mult_acc_sched_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int DEF_ADDR_W = 4;

    // Default-width sideband record; the top re-declares it at its own ADDR_W
    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
        logic                  first;
        logic                  last;
    } sb_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_acc_sched_sb_pipe.sv
// mult_acc_sched_sb_pipe: DEPTH-stage sideband delay line; payload freezes while valid is low.
module mult_acc_sched_sb_pipe #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = mult_acc_sched_pkg::sb_t
) (
    input  logic   clk,
    input  logic   rst,
    input  entry_t din,
    output entry_t dout
);

    entry_t [DEPTH-1:0] stage;
    entry_t [DEPTH:0]   chain;

    assign chain = {stage, din};
    assign dout  = chain[DEPTH];

    // Only valid entries move their payload, so the tail address holds between writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stage <= '0;
        else
            for (int i = 0; i < DEPTH; i++)
                if (chain[i].valid)
                    stage[i] <= chain[i];
                else
                    stage[i].valid <= 1'b0;
    end

endmodule

// File: rtl/mult_acc_sched.sv
// mult_acc_sched: lockstep two-FIFO pop scheduler with pipeline-aligned accumulator controls.
// Define MULT_ACC_SCHED_STALL_CNT_EN to add the stall_cnt output.
module mult_acc_sched
    import mult_acc_sched_pkg::*;
#(
    parameter int AMOUNT_OF_DATA   = 16,
    parameter int AMOUNT_OF_PACKET = 4,
    parameter int PIPE_DEPTH       = 2,
`ifdef MULT_ACC_SCHED_STALL_CNT_EN
    parameter int STALL_CNT_W      = 16,
`endif
    localparam int ADDR_W = addr_w(AMOUNT_OF_DATA)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              f1_empty,
    input  logic              f2_empty,
    output logic              f1_rd,
    output logic              f2_rd,
    output logic              acc_we,
    output logic [ADDR_W-1:0] acc_addr,
    output logic              acc_first,
`ifdef MULT_ACC_SCHED_STALL_CNT_EN
    output logic              res_valid,
    output logic [STALL_CNT_W-1:0] stall_cnt
`else
    output logic              res_valid
`endif
);

    localparam int PKT_W = addr_w(AMOUNT_OF_PACKET);
    localparam int DRN_W = addr_w(PIPE_DEPTH);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              first;
        logic              last;
    } side_t;

    state_t            state, next;
    logic [ADDR_W-1:0] elem_cnt;
    logic [PKT_W-1:0]  pkt_cnt;
    logic [DRN_W-1:0]  drain_cnt;
    logic              pop, last_elem, last_pkt, accept;
    side_t             entry, tail;

    assign last_elem = elem_cnt == ADDR_W'(AMOUNT_OF_DATA - 1);
    assign last_pkt  = pkt_cnt == PKT_W'(AMOUNT_OF_PACKET - 1);
    assign accept    = state == IDLE && start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? RUN : IDLE;
            RUN:     next = (pop && last_elem && last_pkt) ? DRAIN : RUN;
            DRAIN:   next = (drain_cnt == '0) ? IDLE : DRAIN;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        busy  = state != IDLE;
        pop   = state == RUN && !f1_empty && !f2_empty;
        done  = state == DRAIN && drain_cnt == '0;
        f1_rd = pop;
        f2_rd = pop;
    end

    // drain_cnt is reloaded on every pop; only the final pop's value matters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            elem_cnt  <= '0;
            pkt_cnt   <= '0;
            drain_cnt <= '0;
        end else if (accept) begin
            elem_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (pop) begin
            elem_cnt  <= last_elem ? '0 : elem_cnt + 1'b1;
            pkt_cnt   <= !last_elem ? pkt_cnt : (last_pkt ? '0 : pkt_cnt + 1'b1);
            drain_cnt <= DRN_W'(PIPE_DEPTH - 1);
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    assign entry = '{valid: pop, addr: elem_cnt, first: pkt_cnt == '0, last: last_pkt};

    mult_acc_sched_sb_pipe #(
        .DEPTH   (PIPE_DEPTH),
        .entry_t (side_t)
    ) u_sb_pipe (
        .clk  (clk),
        .rst  (rst),
        .din  (entry),
        .dout (tail)
    );

    assign acc_we    = tail.valid;
    assign acc_addr  = tail.addr;
    assign acc_first = tail.first & tail.valid;
    assign res_valid = tail.last & tail.valid;

`ifdef MULT_ACC_SCHED_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (accept)
            stall_cnt <= '0;
        else if (state == RUN && !pop && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_mult_acc_sched.sv
// tb_mult_acc_sched: randomized frame traffic checked cycle by cycle against a pop-index reference model.
module tb_mult_acc_sched;

    localparam int N   = 16;
    localparam int P   = 4;
    localparam int PD  = 2;
    localparam int TOT = N * P;

    logic       clk = 0, rst = 0, start = 0, f1_empty = 1, f2_empty = 1;
    logic       busy, done, f1_rd, f2_rd, acc_we, acc_first, res_valid;
    logic [3:0] acc_addr;
`ifdef MULT_ACC_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    mult_acc_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .f1_empty  (f1_empty),
        .f2_empty  (f2_empty),
        .f1_rd     (f1_rd),
        .f2_rd     (f2_rd),
        .acc_we    (acc_we),
        .acc_addr  (acc_addr),
        .acc_first (acc_first),
`ifdef MULT_ACC_SCHED_STALL_CNT_EN
        .res_valid (res_valid),
        .stall_cnt (stall_cnt)
`else
        .res_valid (res_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int at; int idx;} wr_t;
    wr_t q[$];
    int  tests = 0, fails = 0, cyc = 0, pops = 0, final_cyc = -1, dones = 0, done_cyc = 0;
    int  last_addr = 0, obs_rd = 0, obs_we = 0, m_stall = 0;
    bit  active = 0, ep, ew, ed;

    task automatic check(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference: pop k of a frame lands PD cycles later at slot k%N, packet k/N
    always @(negedge clk) if (rst) begin
        ep = active && pops < TOT && !f1_empty && !f2_empty;
        ew = q.size() > 0 && q[0].at == cyc;
        ed = active && final_cyc >= 0 && cyc == final_cyc + PD;
        check("f1_rd", f1_rd, ep);
        check("f2_rd", f2_rd, ep);
        check("busy", busy, active);
        check("done", done, ed);
        check("acc_we", acc_we, ew);
        if (ew) begin
            check("acc_addr", acc_addr, q[0].idx % N);
            check("acc_first", acc_first, q[0].idx < N);
            check("res_valid", res_valid, q[0].idx >= TOT - N);
            last_addr = q[0].idx % N;
            void'(q.pop_front());
        end else begin
            check("acc_addr_hold", acc_addr, last_addr);
            check("acc_first_idle", acc_first, 0);
            check("res_valid_idle", res_valid, 0);
        end
`ifdef MULT_ACC_SCHED_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_stall);
        if (active && pops < TOT && !ep && m_stall < 65535) m_stall++;
`endif
        obs_rd += int'(f1_rd);
        obs_we += int'(acc_we);
        if (ep) begin
            q.push_back('{cyc + PD, pops});
            if (pops == TOT - 1) final_cyc = cyc;
            pops++;
        end
        if (ed) begin
            active = 0;
            dones++;
            done_cyc = cyc;
        end else if (!active && start) begin
            active = 1;
            pops = 0;
            final_cyc = -1;
            m_stall = 0;
        end
    end

    task automatic frame(input int p1, input int p2, input bit restart, input int stall_at, input int rst_at);
        int d0 = dones, r0 = obs_rd, w0 = obs_we, st = 0, s_cyc;
        bit re10 = 0, aborted = 0;
        @(posedge clk); #1;
        start = 1;
        f1_empty = 0;
        f2_empty = 0;
        s_cyc = cyc;
        for (int b = 0; b < 3000 && dones == d0 && !aborted; b++) begin
            @(posedge clk); #1;
            start = 0;
            f1_empty = $urandom_range(99) < p1;
            f2_empty = $urandom_range(99) < p2;
            if (restart && pops == 10 && !re10) begin
                start = 1;
                re10 = 1;
            end
            if (restart && final_cyc >= 0 && cyc == final_cyc + PD) start = 1;
            if (stall_at >= 0 && pops == stall_at && st < 7) begin
                f1_empty = 1;
                st++;
            end
            if (rst_at >= 0 && pops == rst_at) begin
                #2 rst = 0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_rd", f1_rd | f2_rd, 0);
                check("rst_we", acc_we, 0);
                check("rst_addr", acc_addr, 0);
                check("rst_flags", acc_first | res_valid, 0);
                active = 0;
                q.delete();
                last_addr = 0;
                final_cyc = -1;
                m_stall = 0;
                #3 rst = 1;
                aborted = 1;
            end
        end
        start = 0;
        if (rst_at >= 0) begin
            check("abort_no_done", dones - d0, 0);
        end else begin
            check("frame_done", dones - d0, 1);
            check("frame_pops", obs_rd - r0, TOT);
            check("frame_we", obs_we - w0, TOT);
            if (p1 == 0 && p2 == 0 && stall_at < 0) check("done_latency", done_cyc - s_cyc, TOT + PD);
`ifdef MULT_ACC_SCHED_STALL_CNT_EN
            if (p1 == 0 && p2 == 0 && stall_at >= 0) check("stall_total", stall_cnt, 7);
`endif
        end
    endtask

    initial begin
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd", f1_rd | f2_rd, 0);
        check("reset_we", acc_we, 0);
        check("reset_addr", acc_addr, 0);
        check("reset_flags", acc_first | res_valid, 0);
        @(posedge clk); #3 rst = 1;
        frame(0, 0, 0, -1, -1);
        frame(30, 50, 0, -1, -1);
        frame(0, 0, 1, -1, -1);
        frame(20, 20, 0, -1, 20);
        frame(0, 0, 0, -1, -1);
        frame(10, 10, 0, -1, -1);
        frame(0, 0, 0, -1, -1);
        frame(0, 0, 0, 30, -1);
        frame(15, 5, 0, -1, -1);
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
